// File: rtl/aes128_encrypt_iter_if.sv
// Plaintext-in / ciphertext-out handshake bundle for aes128_encrypt_iter.
interface aes128_encrypt_iter_if;
  logic [127:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dout;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  // Upstream/downstream side (testbench or surrounding logic)
  modport master (
    output din, in_valid, out_ready,
    input  in_ready, dout, out_valid, busy
  );

  // Cipher core side
  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, dout, out_valid, busy
  );
endinterface

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one full round per clock, round keys supplied externally.
// State bytes are column-major with byte 0 in bits [127:120].
module aes128_encrypt_iter (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [127:0]                key_s0,
  input  logic [127:0]                key_s1,
  input  logic [127:0]                key_s2,
  input  logic [127:0]                key_s3,
  input  logic [127:0]                key_s4,
  input  logic [127:0]                key_s5,
  input  logic [127:0]                key_s6,
  input  logic [127:0]                key_s7,
  input  logic [127:0]                key_s8,
  input  logic [127:0]                key_s9,
  input  logic [127:0]                key_s10,
  aes128_encrypt_iter_if.slave        bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StDone  = 2'd2
  } fsm_e;

  localparam logic [7:0] SBox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
    8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
    8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
    8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
    8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
    8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
    8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
    8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
    8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
    8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
    8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
    8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBox[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;
  logic [3:0]   round_q, round_d;
  // Low until the first clock edge with rst_n released, keeps in_ready low during reset.
  logic         rst_done_q, rst_done_d;

  logic [7:0]   sb_b [16];
  logic [7:0]   sr_b [16];
  logic [127:0] round_key;
  logic [127:0] round_out;

  // Round-key select; key_s0 is only consumed at load time.
  always_comb begin
    round_key = '0;
    unique case (round_q)
      4'd1:    round_key = key_s1;
      4'd2:    round_key = key_s2;
      4'd3:    round_key = key_s3;
      4'd4:    round_key = key_s4;
      4'd5:    round_key = key_s5;
      4'd6:    round_key = key_s6;
      4'd7:    round_key = key_s7;
      4'd8:    round_key = key_s8;
      4'd9:    round_key = key_s9;
      4'd10:   round_key = key_s10;
      default: round_key = '0;
    endcase
  end

  // SubBytes: one S-box lookup per state byte.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb_b[i] = sbox(state_q[127 - 8 * i -: 8]);
    end
  end

  // ShiftRows: row r rotates left by r columns.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr_b[r + 4 * c] = sb_b[r + 4 * ((c + r) % 4)];
      end
    end
  end

  // MixColumns (bypassed in the final round) followed by AddRoundKey.
  always_comb begin
    round_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] a0, a1, a2, a3, mixed;
        a0    = sr_b[4 * c + i];
        a1    = sr_b[4 * c + (i + 1) % 4];
        a2    = sr_b[4 * c + (i + 2) % 4];
        a3    = sr_b[4 * c + (i + 3) % 4];
        mixed = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        round_out[127 - 8 * (4 * c + i) -: 8] = (round_q == 4'd10) ? a0 : mixed;
      end
    end
    round_out = round_out ^ round_key;
  end

  // Next-state logic: load, iterate rounds, hold result until taken.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    dout_d     = dout_q;
    round_d    = round_q;
    rst_done_d = 1'b1;
    unique case (fsm_q)
      StIdle: begin
        if (bus.in_valid && rst_done_q) begin
          state_d = bus.din ^ key_s0;
          round_d = 4'd1;
          fsm_d   = StRound;
        end
      end
      StRound: begin
        state_d = round_out;
        if (round_q == 4'd10) begin
          dout_d = round_out;
          fsm_d  = StDone;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= StIdle;
      state_q    <= '0;
      dout_q     <= '0;
      round_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      dout_q     <= dout_d;
      round_q    <= round_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign bus.in_ready  = (fsm_q == StIdle) && rst_done_q;
  assign bus.out_valid = (fsm_q == StDone);
  assign bus.busy      = (fsm_q == StRound);
  assign bus.dout      = dout_q;

endmodule

// File: doc/aes128_encrypt_iter.md
# aes128_encrypt_iter

Iterative AES-128 encryption datapath that consumes the eleven round keys produced by `KeyExpansion` and turns one 128-bit plaintext block into ciphertext. It applies one full round per clock: SubBytes, ShiftRows, MixColumns (skipped in round 10) and AddRoundKey. It sits directly downstream of `KeyExpansion`, with valid/ready handshakes on both the plaintext input and the ciphertext output.

## Interface
- No parameters. Key size is fixed at 128 bits and the round count at 10.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `key_s0` … `key_s10`  input  128 each  round keys 0–10, wired straight from `KeyExpansion`.
- `din`  input  128  plaintext block; byte 0 = `din[127:120]`, bytes in column-major state order (FIPS-197).
- `in_valid`  input  1  `din` is valid.
- `in_ready`  output  1  block can accept a plaintext.
- `dout`  output  128  ciphertext, same byte order as `din`.
- `out_valid`  output  1  `dout` holds a finished ciphertext.
- `out_ready`  input  1  downstream takes `dout`.
- `busy`  output  1  a block is in flight. Upstream must hold the key, and therefore `key_s*`, stable while `busy` or `out_valid` is high.

## Operation
- FSM states: IDLE, ROUND, DONE.
- Registers:
  - 128-bit `state`
  - 4-bit `round` (1..10)
  - 2-bit FSM state
  - registered `dout`
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: `state <= din ^ key_s0`, `round <= 1`, go to ROUND.
- ROUND:
  - Each cycle, `state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key_s[round])`.
  - When `round == 10`, MixColumns is bypassed.
  - `round` increments each cycle.
  - After the round-10 update: `dout <= result`, go to DONE.
- DONE:
  - `out_valid`=1.
  - `dout` and `out_valid` are held stable until `out_valid & out_ready`, then go to IDLE.
- Round-key select: 11:1 mux on `round`. Index 0 is used only at load.
- SubBytes: 16 instances of the existing `sbox` (8-bit in, 8-bit out).
- ShiftRows: row r (bytes r, r+4, r+8, r+12) rotates left by r.
- MixColumns:
  - Per column, GF(2^8) with polynomial 0x11B.
  - `xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00)`.
  - Output row i = `2·a_i ^ 3·a_{i+1} ^ a_{i+2} ^ a_{i+3}`, indices mod 4.
- `in_valid` is ignored outside IDLE. `din` is sampled only at the accept edge.
- `out_ready` is ignored outside DONE.
- `busy` = (state == ROUND).

## Timing
- Reset (`rst_n`=0 at an edge) takes effect the same edge:
  - FSM → IDLE, `round` → 0, `state` → 0, `dout` → 128'h0.
  - `out_valid` → 0, `busy` → 0.
  - `in_ready` = 1 from the first edge with `rst_n` high onward. It is 0 while `rst_n` is low.
- Reset mid-operation, in ROUND or DONE: the block is discarded and no `out_valid` is produced.
- Latency:
  - Accept at edge T.
  - Rounds 1–10 complete at edges T+1 … T+10.
  - `out_valid` is high from edge T+10.
  - Accept → `out_valid` = 10 cycles.
- Output hand-off at edge U (`out_valid & out_ready`): `out_valid` goes low at U and `in_ready` goes high at U. The earliest next accept is edge U+1.
- Back-to-back throughput with `out_ready` tied high is 1 block per 12 cycles.
- `in_ready` and `out_valid` are never high together.
- `in_ready` and `out_valid` are pure decodes of registered state; there is no combinational path from `in_valid` or `out_ready`.

## Test plan
- FIPS-197 C.1: key `000102030405060708090a0b0c0d0e0f`, `din` `00112233445566778899aabbccddeeff` → `dout` `69c4e0d86a7b0430d8cdb78070b4c55a`, with `out_valid` exactly 10 cycles after accept.
- FIPS-197 App. B: key `2b7e151628aed2a6abf7158809cf4f3c`, `din` `3243f6a8885a308d313198a2e0370734` → `3925841d02dc09fbdc118597196a0b32`. Check the intermediate `state` after round 1 is `a49c7ff2689f352b6b5bea43026a5049`.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → `dout` stable, `in_ready`=0, and `in_valid` pulses ignored. Raise `out_ready` → handshake, then `in_ready`=1 on the next cycle.
- Back-to-back: `out_ready` tied to 1, two C.1/App. B blocks queued → both ciphertexts correct, with accepts 12 cycles apart.
- Reset mid-ROUND: drop `rst_n` for 1 cycle at round 5 → `out_valid` never rises for that block, all registers read 0, `in_ready`=1 after reset. A fresh C.1 block then completes correctly.
- All-zero key and plaintext → `66e94bd4ef8a2c3b884cfa59ca342b2e`.
